// File: rtl/video_pkg.sv
// Shared definitions for the video timing receiver: default sizes,
// lock FSM state encoding and the debug view of the measurement core.
package video_pkg;

  localparam int CW_DEFAULT          = 11;
  localparam int LOCK_FRAMES_DEFAULT = 2;

  // Lock FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // One pipeline stage of incoming video (syncs already normalised)
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // Debug view: FSM state, match counter and the edge strobes it reacts to
  typedef struct packed {
    logic [1:0] state;
    logic [3:0] match_cnt;
    logic       de_rise;
    logic       de_fall;
    logic       vs_rise;
    logic       vs_fall;
  } dbg_t;

endpackage

// File: rtl/sig_edge_det.sv
// Edge detector: keeps the previous sample of a level and flags rising
// and falling transitions for exactly one cycle.
module sig_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  // Previous-sample register; cleared so a level high after reset reads as a rise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_d <= 1'b0;
    else       r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;
  assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/video_timing_rx.sv
// Video timing receiver: delays video by two cycles, attaches x/y
// coordinates, measures active width/height and locks onto stable timing.
// Stream semantics: de_out=1 marks a valid pixel on r/g/b_out together with
// its x/y; there is no backpressure, every input cycle is accepted.
module video_timing_rx
  import video_pkg::*;
#(
  parameter int CW             = CW_DEFAULT,
  parameter int LOCK_FRAMES    = LOCK_FRAMES_DEFAULT,
  parameter bit HS_ACTIVE_HIGH = 1'b1,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic          hdmi_clk,
  input  logic          rst,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  output logic          de_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic [CW-1:0] width,
  output logic [CW-1:0] height,
  output logic          locked,
  output logic          err,
  output dbg_t          dbg
);

  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
  localparam logic [3:0]    C_LOCK = 4'(LOCK_FRAMES);

  function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] v);
    return (v == C_MAX) ? v : v + CW'(1);
  endfunction

  pix_t          r_s1, r_s2;
  logic          w_hs_norm, w_vs_norm;
  logic          w_de_rise, w_de_fall, w_vs_rise, w_vs_fall;
  logic [CW-1:0] r_x, r_y, r_width, r_height;
  logic          r_fs, r_fs_pend;
  logic          r_first, r_eq;
  logic [CW-1:0] r_fw;
  logic [CW-1:0] r_ref_w, r_ref_h;
  logic [3:0]    r_cnt;
  logic [1:0]    r_state;
  logic          r_locked, r_err;

  logic [CW-1:0] w_line_w, w_h_now, w_w_now;
  logic          w_eq_now, w_ref_match;
  logic [1:0]    w_nxt_state;
  logic [3:0]    w_nxt_cnt;
  logic [CW-1:0] w_nxt_ref_w, w_nxt_ref_h;
  logic          w_err;

  assign w_hs_norm = HS_ACTIVE_HIGH ? hs_in : ~hs_in;
  assign w_vs_norm = VS_ACTIVE_HIGH ? vs_in : ~vs_in;

  // Stage 1 captures inputs with syncs flipped to active-high; stage 2 re-times them
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1.de <= de_in;
      r_s1.hs <= w_hs_norm;
      r_s1.vs <= w_vs_norm;
      r_s1.r  <= r_in;
      r_s1.g  <= g_in;
      r_s1.b  <= b_in;
      r_s2    <= r_s1;
    end
  end

  sig_edge_det u_de_edge (
    .i_clk  (hdmi_clk),
    .i_rst  (rst),
    .i_d    (r_s1.de),
    .o_rise (w_de_rise),
    .o_fall (w_de_fall)
  );

  sig_edge_det u_vs_edge (
    .i_clk  (hdmi_clk),
    .i_rst  (rst),
    .i_d    (r_s1.vs),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  // Per-frame measurement views; a line ending together with vs still belongs to the old frame
  always_comb begin
    w_line_w    = f_sat_inc(r_x);
    w_h_now     = w_de_fall ? f_sat_inc(r_y) : r_y;
    w_eq_now    = r_eq & (~w_de_fall | r_first | (w_line_w == r_fw));
    w_w_now     = (w_de_fall & r_first) ? w_line_w : r_fw;
    w_ref_match = (w_w_now == r_ref_w) && (w_h_now == r_ref_h);
  end

  // Coordinates, measured size and frame_start, all aligned to stage 2
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_fs      <= 1'b0;
      r_fs_pend <= 1'b0;
    end else begin
      if (r_s1.de) r_x <= w_de_rise ? '0 : f_sat_inc(r_x);
      if (w_vs_rise)      r_y <= '0;
      else if (w_de_fall) r_y <= f_sat_inc(r_y);
      if (w_de_fall) r_width  <= w_line_w;
      if (w_vs_rise) r_height <= w_h_now;
      r_fs <= r_s1.de & r_fs_pend;
      if (w_vs_rise)    r_fs_pend <= 1'b1;
      else if (r_s1.de) r_fs_pend <= 1'b0;
    end
  end

  // Tracks whether every line of the current frame has the same width
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b1;
      r_eq    <= 1'b1;
      r_fw    <= '0;
    end else if (w_vs_rise) begin
      r_first <= 1'b1;
      r_eq    <= 1'b1;
    end else if (w_de_fall) begin
      r_first <= 1'b0;
      if (r_first)                r_fw <= w_line_w;
      else if (w_line_w != r_fw)  r_eq <= 1'b0;
    end
  end

  // Lock FSM next-state: counts matching frames, drops out on any deviation
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_ref_w = r_ref_w;
    w_nxt_ref_h = r_ref_h;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_nxt_state = ST_SEARCH;
          w_nxt_cnt   = 4'd0;
        end
      end
      ST_SEARCH: begin
        if (w_vs_rise) begin
          if ((w_h_now != '0) && w_eq_now) begin
            w_nxt_ref_w = w_w_now;
            w_nxt_ref_h = w_h_now;
            if ((r_cnt == 4'd0) || w_ref_match) w_nxt_cnt = r_cnt + 4'd1;
            else                                w_nxt_cnt = 4'd1;
            if (w_nxt_cnt == C_LOCK) w_nxt_state = ST_LOCKED;
          end else begin
            w_nxt_cnt = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if ((w_de_fall && (w_line_w != r_ref_w)) ||
            (w_vs_rise && (w_h_now != r_ref_h))) begin
          w_err       = 1'b1;
          w_nxt_state = ST_SEARCH;
          w_nxt_cnt   = 4'd0;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Lock FSM registers; locked and err are registered copies of the decision
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_ref_w  <= '0;
      r_ref_h  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_ref_w  <= w_nxt_ref_w;
      r_ref_h  <= w_nxt_ref_h;
      r_locked <= (w_nxt_state == ST_LOCKED);
      r_err    <= w_err;
    end
  end

  // Debug view of the FSM and the strobes driving it
  always_comb begin
    dbg.state     = r_state;
    dbg.match_cnt = r_cnt;
    dbg.de_rise   = w_de_rise;
    dbg.de_fall   = w_de_fall;
    dbg.vs_rise   = w_vs_rise;
    dbg.vs_fall   = w_vs_fall;
  end

  assign de_out      = r_s2.de;
  assign hs_out      = r_s2.hs;
  assign vs_out      = r_s2.vs;
  assign r_out       = r_s2.r;
  assign g_out       = r_s2.g;
  assign b_out       = r_s2.b;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign width       = r_width;
  assign height      = r_height;
  assign locked      = r_locked;
  assign err         = r_err;

endmodule
